// File: rtl/simon_datapath.sv
// simon_datapath: pattern memory, playback/repeat/done counters and status flags for the Simon game
module simon_datapath #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pattern,
  input  logic             pattern_en,
  input  logic [1:0]       select,
  input  logic             clrcount,
  input  logic             w_en,
  output logic             is_legal,
  output logic             play_gt_count,
  output logic             repeat_eq_play,
  output logic             input_eq_pattern,
  output logic             full,
  output logic [WIDTH-1:0] pattern_leds
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  logic [WIDTH-1:0]  r_mem [1<<ADDR_W];
  logic [ADDR_W:0]   r_count, r_play_cnt, r_repeat_cnt, r_done_cnt;
  logic              r_repeat_eq_play, r_input_eq_pattern;
  logic [ADDR_W:0]   w_count_m1;
  logic              w_wr, w_has, w_play_ok;
  logic [WIDTH-1:0]  w_rep_rd, w_play_rd, w_done_rd;
  assign is_legal         = (pattern != '0) && ((pattern & (pattern - 1'b1)) == '0);
  assign full             = r_count == DEPTH;
  assign play_gt_count    = r_play_cnt >= r_count;
  assign repeat_eq_play   = r_repeat_eq_play;
  assign input_eq_pattern = r_input_eq_pattern;
  assign w_count_m1       = r_count - 1'b1;
  assign w_has            = r_count != '0;
  assign w_play_ok        = r_play_cnt < r_count;
  assign w_wr             = !rst && !clrcount && w_en && pattern_en && is_legal && !full;
  assign w_rep_rd         = r_mem[r_repeat_cnt[ADDR_W-1:0]];
  assign w_play_rd        = r_mem[r_play_cnt[ADDR_W-1:0]];
  assign w_done_rd        = r_mem[r_done_cnt[ADDR_W-1:0]];
  always_comb
    pattern_leds = (w_en || select == 2'b01) ? pattern :
                   (select == 2'b00) ? (w_play_ok ? w_play_rd : '0) :
                   (select == 2'b10) ? (w_has ? w_done_rd : '0) : '0;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_count[ADDR_W-1:0]] <= pattern;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clrcount) begin
      r_count            <= '0;
      r_play_cnt         <= '0;
      r_repeat_cnt       <= '0;
      r_done_cnt         <= '0;
      r_input_eq_pattern <= 1'b1;
      r_repeat_eq_play   <= 1'b0;
    end else begin
      r_repeat_eq_play <= 1'b0;
      if (w_en) begin
        r_play_cnt   <= '0;
        r_repeat_cnt <= '0;
        r_done_cnt   <= '0;
        if (w_wr) r_count <= r_count + 1'b1;
      end else begin
        case (select)
          2'b00: begin
            r_repeat_cnt       <= '0;
            r_input_eq_pattern <= 1'b1;
            if (pattern_en && w_play_ok) r_play_cnt <= r_play_cnt + 1'b1;
          end
          2'b01: if (pattern_en) begin
            if (pattern != w_rep_rd) r_input_eq_pattern <= 1'b0;
            else if (w_has && r_repeat_cnt == w_count_m1) begin
              r_repeat_eq_play <= 1'b1;
              r_repeat_cnt     <= '0;
            end else r_repeat_cnt <= r_repeat_cnt + 1'b1;
          end
          2'b10: if (pattern_en && w_has)
            r_done_cnt <= (r_done_cnt == w_count_m1) ? '0 : r_done_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_simon_datapath.sv
// tb_simon_datapath: directed vectors with a stamped expectation queue drained by a negedge monitor
module tb_simon_datapath;
  logic       clk = 0, rst = 1, pattern_en = 0, clrcount = 0, w_en = 0;
  logic [3:0] pattern = '0, pattern_leds;
  logic [1:0] select = 2'b11;
  logic       is_legal, play_gt_count, repeat_eq_play, input_eq_pattern, full;
  typedef struct { string name; int stamp; logic [13:0] exp; } exp_t;
  exp_t q[$];
  int ncyc = 0, n_run = 0, n_fail = 0;
  simon_datapath dut (
    .clk(clk), .rst(rst), .pattern(pattern), .pattern_en(pattern_en),
    .select(select), .clrcount(clrcount), .w_en(w_en), .is_legal(is_legal),
    .play_gt_count(play_gt_count), .repeat_eq_play(repeat_eq_play),
    .input_eq_pattern(input_eq_pattern), .full(full), .pattern_leds(pattern_leds)
  );
  always #5 clk = ~clk;
  // actual = {count, legal, play_gt_count, repeat_eq_play, input_eq_pattern, full, leds}
  always @(negedge clk) begin
    logic [13:0] act;
    exp_t e;
    ncyc = ncyc + 1;
    act = {dut.r_count, is_legal, play_gt_count, repeat_eq_play, input_eq_pattern, full, pattern_leds};
    while (q.size() != 0 && q[0].stamp <= ncyc) begin
      e = q.pop_front();
      n_run++;
      if (e.stamp < ncyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got cnt=%0d lg=%b pgc=%b rep=%b ieq=%b full=%b leds=%b, need cnt=%0d lg=%b pgc=%b rep=%b ieq=%b full=%b leds=%b",
          e.name, act[13:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
          e.exp[13:9], e.exp[8], e.exp[7], e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
    end
  end
  task automatic chk(input string n, input logic [4:0] c, input logic l, p, r, i, f, input logic [3:0] led);
    q.push_back('{n, ncyc + 1, {c, l, p, r, i, f, led}});
    @(negedge clk); #1;
  endtask
  task automatic press(input logic [3:0] pv);
    pattern = pv; pattern_en = 1;
    @(posedge clk); #1 pattern_en = 0;
  endtask
  task automatic idle();
    @(posedge clk); #1;
  endtask
  initial begin
    @(negedge clk); #1;
    chk("reset_held", 0, 0, 1, 0, 1, 0, 4'h0);
    rst = 0;
    idle(); chk("reset_idle", 0, 0, 1, 0, 1, 0, 4'h0);
    w_en = 1;
    press(4'h1); chk("t1_w1", 1, 1, 0, 0, 1, 0, 4'h1);
    press(4'h2); chk("t1_w2", 2, 1, 0, 0, 1, 0, 4'h2);
    press(4'h4); chk("t1_w3", 3, 1, 0, 0, 1, 0, 4'h4);
    press(4'h3); chk("t1_illegal", 3, 0, 0, 0, 1, 0, 4'h3);
    w_en = 0; select = 2'b00; pattern = 4'h0;
    chk("t2_pb0", 3, 0, 0, 0, 1, 0, 4'h1);
    press(4'h0); chk("t2_pb1", 3, 0, 0, 0, 1, 0, 4'h2);
    press(4'h0); chk("t2_pb2", 3, 0, 0, 0, 1, 0, 4'h4);
    press(4'h0); chk("t2_pb_done", 3, 0, 1, 0, 1, 0, 4'h0);
    select = 2'b01;
    press(4'h1); chk("t3_r1", 3, 1, 1, 0, 1, 0, 4'h1);
    press(4'h2); chk("t3_r2", 3, 1, 1, 0, 1, 0, 4'h2);
    press(4'h4); chk("t3_pulse", 3, 1, 1, 1, 1, 0, 4'h4);
    idle();      chk("t3_pulse_end", 3, 1, 1, 0, 1, 0, 4'h4);
    press(4'h1); chk("t4_r1", 3, 1, 1, 0, 1, 0, 4'h1);
    press(4'h8); chk("t4_mismatch", 3, 1, 1, 0, 0, 0, 4'h8);
    idle();      chk("t4_sticky1", 3, 1, 1, 0, 0, 0, 4'h8);
    idle();      chk("t4_sticky2", 3, 1, 1, 0, 0, 0, 4'h8);
    select = 2'b00;
    idle();      chk("t4_pb_restore", 3, 1, 1, 0, 1, 0, 4'h0);
    select = 2'b11; pattern = 4'h0; clrcount = 1;
    idle(); clrcount = 0;
    chk("t5_clr", 0, 0, 1, 0, 1, 0, 4'h0);
    w_en = 1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] pv;
      pv = 4'h1 << (i % 4);
      press(pv); chk($sformatf("t5_w%0d", i), 5'(i + 1), 1, 0, 0, 1, (i == 15), pv);
    end
    press(4'h1); chk("t5_full_hold", 16, 1, 0, 0, 1, 1, 4'h1);
    w_en = 0; select = 2'b10; pattern = 4'h0;
    chk("t5_done0", 16, 0, 0, 0, 1, 1, 4'h1);
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] lv;
      lv = 4'h1 << (k % 4);
      press(4'h0); chk($sformatf("t5_done_p%0d", k), 16, 0, 0, 0, 1, 1, lv);
    end
    select = 2'b01;
    press(4'h1); chk("t6_r1", 16, 1, 0, 0, 1, 1, 4'h1);
    press(4'h1); chk("t6_mismatch", 16, 1, 0, 0, 0, 1, 4'h1);
    @(posedge clk); #2 rst = 1;
    chk("t6_async_rst", 0, 1, 1, 0, 1, 0, 4'h1);
    rst = 0;
    clrcount = 1; w_en = 1; pattern = 4'h1; pattern_en = 1;
    @(posedge clk); #1 clrcount = 0; pattern_en = 0;
    chk("t6_clr_nowrite", 0, 1, 1, 0, 1, 0, 4'h1);
    press(4'h2); chk("t6_write_after", 1, 1, 0, 0, 1, 0, 4'h2);
    for (int t = 0; t < 10 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
